am_error_monitor: RTL and testbench

- Sequential statistics stage directly downstream of the unsigned WxW approximate multipliers.
- Each sample carries the operand pair and the product the multiplier under test produced. The block computes the exact product and the error distance, and accumulates frame statistics.
- Statistics are: sum of absolute error, sum of signed error, maximum absolute error, count of erroneous samples and sample count.
- The hardware bench and the FPGA harness use it to score candidate multipliers on live traffic.

---
 rtl/am_error_monitor.sv | 152 +++++++++++++++
 tb/tb_am_error_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_error_monitor.sv
// Error-statistics stage for WxW approximate multipliers: exact product, error distance, frame stats.
// Optional macro AM_STATS_SAT_EN makes the two error accumulators saturate instead of wrap.
module am_error_monitor #(
  parameter int unsigned W         = 8,
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_x,
  input  logic [W-1:0]       in_y,
  input  logic [2*W-1:0]     in_z,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_sum_abs,
  output logic [ACC_W-1:0]   res_sum_signed,
  output logic [2*W-1:0]     res_max_abs,
  output logic [CNT_W-1:0]   res_err_cnt,
  output logic [CNT_W-1:0]   res_sample_cnt,
  output logic               busy
);

  localparam int unsigned PW = 2 * W;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  logic [1:0] state, state_nx;
  logic in_ready_nx, busy_nx, res_valid_nx;
  logic accept, clear;

  logic                 s1_valid, s2_valid;
  logic [PW-1:0]        s1_exact, s1_z, s2_abs, abs_c;
  logic signed [PW:0]   s2_err, err_c;
  logic [ACC_W-1:0]     sum_abs_nx, sum_signed_nx;

  assign accept = in_valid & in_ready;
  assign clear  = (state == IDLE) & start;

  // Next-state and registered-output decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && (res_sample_cnt + CNT_W'(1) == LAST_CNT)) state_nx = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_nx = REPORT;
      REPORT:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    in_ready_nx  = (state_nx == RUN);
    busy_nx      = (state_nx == RUN) || (state_nx == DRAIN);
    res_valid_nx = (state_nx == REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= in_ready_nx;
      busy      <= busy_nx;
      res_valid <= res_valid_nx;
    end
  end

  // S1: exact product; S2: signed error and its magnitude
  assign err_c = $signed({1'b0, s1_z}) - $signed({1'b0, s1_exact});
  assign abs_c = err_c[PW] ? PW'(-err_c) : PW'(err_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_exact <= '0;
      s1_z     <= '0;
      s2_valid <= 1'b0;
      s2_err   <= '0;
      s2_abs   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_exact <= PW'(in_x) * PW'(in_y);
        s1_z     <= in_z;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_err <= err_c;
        s2_abs <= abs_c;
      end
    end
  end

`ifdef AM_STATS_SAT_EN
  logic [ACC_W:0]        abs_sum_w;
  logic signed [ACC_W:0] sgn_sum_w;
  logic                  sgn_ovf, sgn_sat_q;

  assign abs_sum_w = {1'b0, res_sum_abs} + (ACC_W+1)'(s2_abs);
  assign sgn_sum_w = (ACC_W+1)'($signed(res_sum_signed)) + (ACC_W+1)'(s2_err);
  assign sgn_ovf   = sgn_sum_w[ACC_W] ^ sgn_sum_w[ACC_W-1];

  // Signed sum pins at its rail for the rest of the frame once it clips
  always_comb begin
    sum_abs_nx    = abs_sum_w[ACC_W] ? {ACC_W{1'b1}} : abs_sum_w[ACC_W-1:0];
    sum_signed_nx = sgn_sum_w[ACC_W-1:0];
    if (sgn_sat_q)
      sum_signed_nx = res_sum_signed;
    else if (sgn_ovf)
      sum_signed_nx = {sgn_sum_w[ACC_W], {(ACC_W-1){~sgn_sum_w[ACC_W]}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        sgn_sat_q <= 1'b0;
    else if (clear)                 sgn_sat_q <= 1'b0;
    else if (s2_valid && sgn_ovf)   sgn_sat_q <= 1'b1;
  end
`else
  logic signed [ACC_W-1:0] err_ext;

  assign err_ext       = ACC_W'(s2_err);
  assign sum_abs_nx    = res_sum_abs + ACC_W'(s2_abs);
  assign sum_signed_nx = res_sum_signed + err_ext;
`endif

  // Frame statistics double as the result registers; they hold until the next start
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      res_sum_abs    <= '0;
      res_sum_signed <= '0;
      res_max_abs    <= '0;
      res_err_cnt    <= '0;
      res_sample_cnt <= '0;
    end else begin
      if (accept) res_sample_cnt <= res_sample_cnt + CNT_W'(1);
      if (s2_valid) begin
        res_sum_abs    <= sum_abs_nx;
        res_sum_signed <= sum_signed_nx;
        if (s2_abs > res_max_abs) res_max_abs <= s2_abs;
        if (s2_err != '0) res_err_cnt <= res_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_am_error_monitor.sv
// Scoreboard bench for am_error_monitor: a 4-sample-frame instance and a 17-bit-accumulator
// instance for saturation/wrap (expectations follow AM_STATS_SAT_EN).
module tb_am_error_monitor;

  typedef struct packed {
    logic [31:0] sa;
    logic [31:0] ss;
    logic [15:0] mx;
    logic [15:0] ec;
    logic [15:0] sc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        start, in_valid, in_ready, res_valid, res_ready, busy;
  logic [7:0]  in_x, in_y;
  logic [15:0] in_z;
  logic [31:0] res_sum_abs, res_sum_signed;
  logic [15:0] res_max_abs, res_err_cnt, res_sample_cnt;

  logic        s_start, s_in_valid, s_in_ready, s_res_valid, s_res_ready, s_busy;
  logic [7:0]  s_in_x, s_in_y;
  logic [15:0] s_in_z;
  logic [16:0] s_res_sum_abs, s_res_sum_signed;
  logic [15:0] s_res_max_abs, s_res_err_cnt, s_res_sample_cnt;

  res_t mq[$];
  res_t sq[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  am_error_monitor #(.W(8), .FRAME_LEN(4), .ACC_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum_abs(res_sum_abs), .res_sum_signed(res_sum_signed), .res_max_abs(res_max_abs),
    .res_err_cnt(res_err_cnt), .res_sample_cnt(res_sample_cnt), .busy(busy)
  );

  am_error_monitor #(.W(8), .FRAME_LEN(40), .ACC_W(17), .CNT_W(16)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_x(s_in_x), .in_y(s_in_y), .in_z(s_in_z), .res_valid(s_res_valid), .res_ready(s_res_ready),
    .res_sum_abs(s_res_sum_abs), .res_sum_signed(s_res_sum_signed), .res_max_abs(s_res_max_abs),
    .res_err_cnt(s_res_err_cnt), .res_sample_cnt(s_res_sample_cnt), .busy(s_busy)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitors: pop one expected frame when res_valid rises, re-check it every REPORT cycle
  res_t m_cur;
  bit   m_have = 1'b0;
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (!m_have) begin
        m_have = 1'b1;
        chk("main_report_expected", (mq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (mq.size() > 0) m_cur = mq.pop_front();
        else               m_cur = '0;
      end
      chk("main_sum_abs",    res_sum_abs,           m_cur.sa);
      chk("main_sum_signed", res_sum_signed,        m_cur.ss);
      chk("main_max_abs",    32'(res_max_abs),      32'(m_cur.mx));
      chk("main_err_cnt",    32'(res_err_cnt),      32'(m_cur.ec));
      chk("main_sample_cnt", 32'(res_sample_cnt),   32'(m_cur.sc));
    end else begin
      m_have = 1'b0;
    end
  end

  res_t s_cur;
  bit   s_have = 1'b0;
  always @(negedge clk) begin
    if (s_res_valid === 1'b1) begin
      if (!s_have) begin
        s_have = 1'b1;
        chk("sat_report_expected", (sq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sq.size() > 0) s_cur = sq.pop_front();
        else               s_cur = '0;
      end
      chk("sat_sum_abs",    32'(s_res_sum_abs),    s_cur.sa);
      chk("sat_sum_signed", 32'(s_res_sum_signed), s_cur.ss);
      chk("sat_max_abs",    32'(s_res_max_abs),    32'(s_cur.mx));
      chk("sat_err_cnt",    32'(s_res_err_cnt),    32'(s_cur.ec));
      chk("sat_sample_cnt", 32'(s_res_sample_cnt), 32'(s_cur.sc));
    end else begin
      s_have = 1'b0;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Present one sample and return at the negedge after it is accepted (in_valid left high)
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] z);
    int k = 0;
    in_valid = 1'b1; in_x = x; in_y = y; in_z = z;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: in_ready never rose, got %0d cycles expected <50", k);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at the negedge after the final acceptance edge t
  task automatic check_tail(input bit drop_valid);
    chk("in_ready_after_last", 32'(in_ready), 32'd0);
    if (drop_valid) in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("res_valid_before_t3", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("res_valid_at_t3", 32'(res_valid), 32'd1);
  endtask

  task automatic finish_frame(input int stall);
    int k = 0;
    while (res_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("report_reached", 32'(res_valid), 32'd1);
    repeat (stall) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("idle_res_valid", 32'(res_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, got %0t expected <100000", $time);
    $fatal(1);
  end

  initial begin
    int n, k;
    start = 0; in_valid = 0; res_ready = 0; in_x = 0; in_y = 0; in_z = 0;
    s_start = 0; s_in_valid = 0; s_res_ready = 1; s_in_x = 0; s_in_y = 0; s_in_z = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy",       32'(busy),           32'd0);
    chk("rst_in_ready",   32'(in_ready),       32'd0);
    chk("rst_res_valid",  32'(res_valid),      32'd0);
    chk("rst_sum_abs",    res_sum_abs,         32'd0);
    chk("rst_sample_cnt", 32'(res_sample_cnt), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Zero error, back-to-back
    mq.push_back('{32'd0, 32'd0, 16'd0, 16'd0, 16'd4});
    pulse_start();
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_in_ready", 32'(in_ready), 32'd1);
    send(8'd3, 8'd5, 16'd15);
    send(8'd255, 8'd255, 16'd65025);
    send(8'd0, 8'd7, 16'd0);
    send(8'd16, 8'd16, 16'd256);
    check_tail(1'b1);
    finish_frame(0);

    // Mixed signs: -3585 and +4
    mq.push_back('{32'd3589, 32'hFFFFF203, 16'd3585, 16'd2, 16'd4});
    pulse_start();
    send(8'd255, 8'd255, 16'hF000);
    send(8'd16, 8'd16, 16'd260);
    send(8'd1, 8'd1, 16'd1);
    send(8'd2, 8'd3, 16'd6);
    check_tail(1'b1);
    finish_frame(0);

    // Gapped input and a 5-cycle result stall
    mq.push_back('{32'd65544, 32'd65542, 16'd65535, 16'd3, 16'd4});
    pulse_start();
    send(8'd10, 8'd10, 16'd99);
    idle(2);
    send(8'd3, 8'd4, 16'd20);
    idle(1);
    send(8'd200, 8'd2, 16'd400);
    idle(3);
    send(8'd0, 8'd0, 16'hFFFF);
    check_tail(1'b1);
    finish_frame(5);
    repeat (2) @(negedge clk);
    chk("idle_hold_sum_abs", res_sum_abs, 32'd65544);

    // in_valid in IDLE, start in RUN and REPORT, in_valid in DRAIN are all ignored
    in_valid = 1'b1; in_x = 8'd0; in_y = 8'd0; in_z = 16'd5;
    repeat (3) @(negedge clk);
    chk("idle_in_ready_valid_high", 32'(in_ready), 32'd0);
    chk("idle_sample_cnt_held", 32'(res_sample_cnt), 32'd4);
    in_valid = 1'b0;
    mq.push_back('{32'd5, 32'hFFFFFFFD, 16'd4, 16'd2, 16'd4});
    pulse_start();
    chk("start_clears_sum_abs", res_sum_abs, 32'd0);
    chk("start_clears_sample_cnt", 32'(res_sample_cnt), 32'd0);
    send(8'd7, 8'd7, 16'd50);
    start = 1'b1;
    send(8'd8, 8'd8, 16'd60);
    start = 1'b0;
    send(8'd9, 8'd9, 16'd81);
    send(8'd1, 8'd2, 16'd2);
    in_x = 8'd0; in_y = 8'd0; in_z = 16'h1234;
    check_tail(1'b0);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_in_report_ignored", 32'(res_valid), 32'd1);
    finish_frame(2);
    chk("report_start_no_clear", res_sum_abs, 32'd5);

    // Async reset mid-frame, between clock edges
    pulse_start();
    send(8'd100, 8'd100, 16'd0);
    send(8'd2, 8'd2, 16'd5);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",       32'(busy),           32'd0);
    chk("arst_in_ready",   32'(in_ready),       32'd0);
    chk("arst_res_valid",  32'(res_valid),      32'd0);
    chk("arst_sum_abs",    res_sum_abs,         32'd0);
    chk("arst_sum_signed", res_sum_signed,      32'd0);
    chk("arst_max_abs",    32'(res_max_abs),    32'd0);
    chk("arst_err_cnt",    32'(res_err_cnt),    32'd0);
    chk("arst_sample_cnt", 32'(res_sample_cnt), 32'd0);
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_pipe_flushed", res_sum_abs, 32'd0);
    mq.push_back('{32'd1, 32'd1, 16'd1, 16'd1, 16'd4});
    pulse_start();
    send(8'd2, 8'd2, 16'd5);
    send(8'd3, 8'd3, 16'd9);
    send(8'd4, 8'd4, 16'd16);
    send(8'd5, 8'd5, 16'd25);
    check_tail(1'b1);
    finish_frame(0);

    // 17-bit accumulators, 40 samples of err = -3585
`ifdef AM_STATS_SAT_EN
    sq.push_back('{32'd131071, 32'h00010000, 16'd3585, 16'd40, 16'd40});
`else
    sq.push_back('{32'd12328, 32'h0001CFD8, 16'd3585, 16'd40, 16'd40});
`endif
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    chk("sat_busy", 32'(s_busy), 32'd1);
    s_in_valid = 1'b1; s_in_x = 8'd255; s_in_y = 8'd255; s_in_z = 16'hF000;
    n = 0; k = 0;
    while (s_res_valid !== 1'b1 && k < 200) begin
      if (s_in_ready === 1'b1) n++;
      @(negedge clk);
      k++;
    end
    s_in_valid = 1'b0;
    chk("sat_acceptances", 32'(n), 32'd40);
    repeat (3) @(negedge clk);

    chk("main_queue_drained", 32'(mq.size()), 32'd0);
    chk("sat_queue_drained", 32'(sq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
